// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: N requesters share one WIDTH-bit register through a
// round-robin arbiter. A requester can hold a lock for up to LOCK_MAX cycles.
// Ports:
//   CLK       - clock, rising edge
//   RESETN    - synchronous active-low reset
//   I_VALID   - per-requester write request
//   I         - per-requester write data, requester k at [k*WIDTH +: WIDTH]
//   I_LOCK    - per-requester lock request
//   I_READY   - per-requester grant (combinational, one-hot or zero)
//   O         - shared register contents
//   O_OWNER   - index of the last writer
//   O_UPDATED - pulses for one cycle after each transfer
//   O_LOCKED  - high while a lock is held
module reg_share_arbiter #(
    parameter int unsigned     WIDTH    = 8,
    parameter int unsigned     N        = 4,
    parameter logic [WIDTH-1:0] INIT    = '0,
    parameter int unsigned     LOCK_MAX = 8
) (
    input  logic                          CLK,
    input  logic                          RESETN,
    input  logic [N-1:0]                  I_VALID,
    input  logic [N*WIDTH-1:0]            I,
    input  logic [N-1:0]                  I_LOCK,
    output logic [N-1:0]                  I_READY,
    output logic [WIDTH-1:0]              O,
    output logic [((N>1)?$clog2(N):1)-1:0] O_OWNER,
    output logic                          O_UPDATED,
    output logic                          O_LOCKED
);

    localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LW = 8;

    typedef enum logic {ST_ARB, ST_LOCKED} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [LW-1:0]   lcnt_q, lcnt_d;

    logic [WIDTH-1:0] din [N];
    logic [OW-1:0]   arb_idx;
    logic [OW-1:0]   scan_idx;
    logic            arb_found;
    logic [OW-1:0]   xfer_idx;
    logic            xfer;
    logic [N-1:0]    ready_c;

    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] k);
        if (32'(k) == N - 1) return '0;
        return k + OW'(1);
    endfunction

    // Unpack the flat data bus into one word per requester.
    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            din[k] = I[k*WIDTH +: WIDTH];
        end
    end

    // Round-robin search starting at ptr_q.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            scan_idx = OW'((32'(ptr_q) + i) % N);
            if (!arb_found && I_VALID[scan_idx]) begin
                arb_found = 1'b1;
                arb_idx   = scan_idx;
            end
        end
    end

    // Grant: lock owner always wins while locked; nothing during reset.
    always_comb begin
        ready_c = '0;
        if (RESETN) begin
            if (state_q == ST_LOCKED) ready_c[owner_q] = 1'b1;
            else if (arb_found)       ready_c[arb_idx] = 1'b1;
        end
    end

    assign I_READY  = ready_c;
    assign xfer_idx = (state_q == ST_LOCKED) ? owner_q : arb_idx;
    assign xfer     = |(I_VALID & ready_c);
    assign O_LOCKED = (state_q == ST_LOCKED);

    // Next-state: lock entry, lock extension and release.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            ST_ARB: begin
                if (xfer && I_LOCK[xfer_idx]) begin
                    state_d = ST_LOCKED;
                    owner_d = xfer_idx;
                    lcnt_d  = LW'(1);
                end else if (xfer) begin
                    ptr_d = wrap_inc(xfer_idx);
                end
            end
            ST_LOCKED: begin
                if (I_LOCK[owner_q] && (lcnt_q < LW'(LOCK_MAX))) begin
                    lcnt_d = lcnt_q + LW'(1);
                end else begin
                    state_d = ST_ARB;
                    ptr_d   = wrap_inc(owner_q);
                    lcnt_d  = '0;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // State and arbitration registers.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= ST_ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // Shared register and its status.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            O         <= INIT;
            O_OWNER   <= '0;
            O_UPDATED <= 1'b0;
        end else begin
            O_UPDATED <= xfer;
            if (xfer) begin
                O       <= din[xfer_idx];
                O_OWNER <= xfer_idx;
            end
        end
    end

endmodule
